// File: rtl/pn_ring_pkg.sv
// Ring geometry for the dining-philosophers Petri net: 10 places, 10 transitions.
// Latency: n/a (constants and pure index lookups only).
// Backpressure: n/a.
package pn_ring_pkg;

  localparam int NT = 10;
  localparam logic [NT-1:0] INIT_MARK_DEF = 10'h092;

  typedef logic [3:0] place_idx_t;
  typedef logic [3:0] trans_idx_t;

  // Input place of transition t (token consumed when t fires)
  function automatic place_idx_t pre_place(input trans_idx_t t);
    case (t)
      4'd0:    return 4'd1;
      4'd1:    return 4'd0;
      4'd2:    return 4'd3;
      4'd3:    return 4'd2;
      4'd4:    return 4'd5;
      4'd5:    return 4'd4;
      4'd6:    return 4'd7;
      4'd7:    return 4'd6;
      4'd8:    return 4'd9;
      default: return 4'd8;
    endcase
  endfunction

  // Output place of transition t (token produced when t fires)
  function automatic place_idx_t post_place(input trans_idx_t t);
    case (t)
      4'd0:    return 4'd2;
      4'd1:    return 4'd1;
      4'd2:    return 4'd4;
      4'd3:    return 4'd3;
      4'd4:    return 4'd6;
      4'd5:    return 4'd5;
      4'd6:    return 4'd8;
      4'd7:    return 4'd7;
      4'd8:    return 4'd0;
      default: return 4'd9;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_nt.sv
// Round-robin pick of one candidate transition, scanning upward from rr_ptr.
// Latency: purely combinational.
// Backpressure: none; an empty candidate set gives valid=0 and a zero grant.
module rr_arbiter_nt
  import pn_ring_pkg::*;
(
  input  logic [NT-1:0] cand,
  input  trans_idx_t    rr_ptr,
  output logic [NT-1:0] grant,
  output trans_idx_t    grant_idx,
  output logic          valid
);

  // First set candidate at or after rr_ptr, wrapping modulo NT
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NT; off++) begin
      idx = (int'(rr_ptr) + off) % NT;
      if (!valid && cand[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = trans_idx_t'(idx);
      end
    end
  end

endmodule

// File: rtl/pn_transition_scheduler.sv
// Turns level firing requests into one-cycle transition strobes for the 10-place ring FSM.
// Latency: request sampled at edge N, strobe/ack registered and high for cycle N..N+1.
// Backpressure: requests for disabled places are held pending; stall flags long starvation.
module pn_transition_scheduler
  import pn_ring_pkg::*;
#(
  parameter logic [NT-1:0] INIT_MARK   = INIT_MARK_DEF,
  parameter int            STALL_LIMIT = 16,
  parameter int            CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NT-1:0]    req,
  output logic [NT-1:0]    ack,
  output logic [NT-1:0]    t_,
  output logic [NT-1:0]    marking,
  output logic             stall,
  output logic [CNT_W-1:0] fire_count
);

  logic [NT-1:0] strobe;
  logic [NT-1:0] enabled;
  logic [NT-1:0] cand;
  logic [NT-1:0] grant;
  logic [NT-1:0] pre_oh;
  logic [NT-1:0] post_oh;
  trans_idx_t    grant_idx;
  trans_idx_t    rr_ptr;
  logic          grant_vld;
  logic [15:0]   stall_cnt;

  // Transition enabled when its input place holds a token and its output place is free
  always_comb begin
    enabled = '0;
    for (int i = 0; i < NT; i++) begin
      enabled[i] = marking[pre_place(trans_idx_t'(i))] & ~marking[post_place(trans_idx_t'(i))];
    end
  end

  // A request still high during its own ack cycle is the old one and must not be re-granted
  assign cand = req & enabled & ~strobe;

  rr_arbiter_nt u_arb (
    .cand      (cand),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_vld)
  );

  // Token move masks for the granted transition
  always_comb begin
    pre_oh  = '0;
    post_oh = '0;
    pre_oh[pre_place(grant_idx)]   = 1'b1;
    post_oh[post_place(grant_idx)] = 1'b1;
  end

  // Strobe, marking, pointer, counters; reset cuts any strobe in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe     <= '0;
      marking    <= INIT_MARK;
      rr_ptr     <= '0;
      fire_count <= '0;
      stall_cnt  <= '0;
    end else begin
      strobe <= grant;
      if (grant_vld) begin
        marking    <= (marking & ~pre_oh) | post_oh;
        rr_ptr     <= (grant_idx == trans_idx_t'(NT - 1)) ? '0 : grant_idx + 4'd1;
        fire_count <= fire_count + CNT_W'(1);
      end
      if (grant_vld || (req == '0)) begin
        stall_cnt <= '0;
      end else if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign t_    = strobe;
  assign ack   = strobe;
  assign stall = (int'(stall_cnt) >= STALL_LIMIT);

endmodule

// File: tb/tb_pn_transition_scheduler.sv
// Directed and random checks of the transition scheduler against a reference ring model.
// Latency: expected values are queued at drive time and compared 1 time unit after the edge.
// Backpressure: requests are held until their ack is observed, then dropped.
module tb_pn_transition_scheduler;

  localparam int NT  = 10;
  localparam int LIM = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NT-1:0] req = '0;
  logic [NT-1:0] ack;
  logic [NT-1:0] t_;
  logic [NT-1:0] marking;
  logic          stall;
  logic [CW-1:0] fire_count;

  always #5 clk = ~clk;

  pn_transition_scheduler #(
    .INIT_MARK   (10'h092),
    .STALL_LIMIT (LIM),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .t_         (t_),
    .marking    (marking),
    .stall      (stall),
    .fire_count (fire_count)
  );

  typedef struct packed {
    logic [NT-1:0] t;
    logic [NT-1:0] mark;
    logic [CW-1:0] cnt;
    logic          stl;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Reference model of the ring, taken from the transition map
  int PRE  [NT] = '{1, 0, 3, 2, 5, 4, 7, 6, 9, 8};
  int POST [NT] = '{2, 1, 4, 3, 6, 5, 8, 7, 0, 9};
  logic [NT-1:0] m_mark;
  logic [NT-1:0] m_t;
  int            m_ptr;
  logic [CW-1:0] m_cnt;
  int            m_scnt;
  int            mon_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mark  = 10'h092;
    m_t     = '0;
    m_ptr   = 0;
    m_cnt   = '0;
    m_scnt  = 0;
    mon_cnt = 0;
  endtask

  // Predict one clock edge, queue the prediction, advance the clock, compare
  task automatic step(input string tag);
    logic [NT-1:0] en;
    logic [NT-1:0] cand;
    int            g;
    exp_t          e;
    for (int i = 0; i < NT; i++) en[i] = m_mark[PRE[i]] & ~m_mark[POST[i]];
    cand = req & en & ~m_t;
    g = -1;
    for (int off = 0; off < NT; off++) begin
      if (g < 0 && cand[(m_ptr + off) % NT]) g = (m_ptr + off) % NT;
    end
    m_t = '0;
    if (g >= 0) begin
      m_t[g] = 1'b1;
      m_mark[PRE[g]]  = 1'b0;
      m_mark[POST[g]] = 1'b1;
      m_ptr  = (g + 1) % NT;
      m_cnt  = m_cnt + 1'b1;
      m_scnt = 0;
    end else if (req == '0) begin
      m_scnt = 0;
    end else if (m_scnt < 65535) begin
      m_scnt++;
    end
    e.t    = m_t;
    e.mark = m_mark;
    e.cnt  = m_cnt;
    e.stl  = (m_scnt >= LIM);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("%s/t_", tag), 32'(t_), 32'(e.t));
    check($sformatf("%s/ack", tag), 32'(ack), 32'(e.t));
    check($sformatf("%s/marking", tag), 32'(marking), 32'(e.mark));
    check($sformatf("%s/fire_count", tag), 32'(fire_count), 32'(e.cnt));
    check($sformatf("%s/stall", tag), 32'(stall), 32'(e.stl));
    if (t_ != '0) mon_cnt++;
  endtask

  initial begin
    // Reset held for three cycles
    reset = 1'b0;
    req   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst/marking", 32'(marking), 32'h092);
    check("rst/t_", 32'(t_), 32'h0);
    check("rst/ack", 32'(ack), 32'h0);
    check("rst/stall", 32'(stall), 32'h0);
    check("rst/fire_count", 32'(fire_count), 32'h0);
    reset = 1'b1;

    // Single fire of t6: p7 -> p8
    req = 10'h040;
    step("single");
    check("single/t6", 32'(t_), 32'h040);
    check("single/mark", 32'(marking), 32'h112);
    check("single/count", 32'(fire_count), 32'd1);
    req = '0;
    step("single_idle");

    // t8 needs p9, which stays empty: never fires, stall after LIM cycles
    req = 10'h100;
    repeat (LIM - 1) step("disabled");
    check("disabled/stall_pre", 32'(stall), 32'h0);
    step("disabled");
    check("disabled/stall_set", 32'(stall), 32'h1);
    check("disabled/no_fire", 32'(fire_count), 32'd1);
    req = '0;
    step("disabled_clear");
    check("disabled/stall_clr", 32'(stall), 32'h0);

    // Round robin from reset: t0, then t5, then t6
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = 10'h061;
    step("rr1");
    check("rr/first_t0", 32'(t_), 32'h001);
    req[0] = 1'b0;
    step("rr2");
    check("rr/second_t5", 32'(t_), 32'h020);
    req[5] = 1'b0;
    step("rr3");
    check("rr/third_t6", 32'(t_), 32'h040);
    req = '0;
    step("rr_idle");

    // Reset dropped while t0 strobe is high
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = 10'h001;
    step("midfire");
    check("midfire/strobe", 32'(t_), 32'h001);
    reset = 1'b0;
    #1;
    check("midfire/t_cut", 32'(t_), 32'h0);
    check("midfire/ack_cut", 32'(ack), 32'h0);
    check("midfire/mark", 32'(marking), 32'h092);
    check("midfire/count", 32'(fire_count), 32'h0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random run with held requests and invariant checks
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NT; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
      step("rand");
      req = req & ~m_t;
      check("rand/tokens", $countones(marking), 32'd3);
      check("rand/onehot0", 32'($onehot0(t_)), 32'd1);
    end
    check("rand/monitor_count", 32'(fire_count), 32'(mon_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
